// File: rtl/fifo_pkg.sv
// Shared FIFO constants and elaboration-time helpers used by the memory-logic FIFOs.
package fifo_pkg;

   localparam int FIFO_DEFAULT_WIDTH = 8;
   localparam int FIFO_DEFAULT_DEPTH = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: one write port, one registered read port.
// Storage is never reset; only the read-data register returns to zero.
module fifo_mem_sdp #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read-before-write: a same-address write this edge is not visible here.
   always_ff @(posedge i_clk) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush,
// and sticky overflow/underflow error bits.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_we,
   input  logic                     i_re,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_dout_valid,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic [clog2(DEPTH):0]    o_count,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);
   localparam logic [AW:0] C_AF    = (AW + 1)'(AF_THRESH);
   localparam logic [AW:0] C_AE    = (AW + 1)'(AE_THRESH);

   generate
      if (!is_pow2(DEPTH)) begin : g_bad_depth
         $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
      end
      if (AF_THRESH > DEPTH || AF_THRESH < 0) begin : g_bad_af
         $error("sync_fifo_flags: AF_THRESH out of range");
      end
      if (AE_THRESH >= DEPTH || AE_THRESH < 0) begin : g_bad_ae
         $error("sync_fifo_flags: AE_THRESH out of range");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("sync_fifo_flags: WIDTH must be >= 1");
      end
   endgenerate

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] r_count;
   logic        r_dout_valid;
   logic        r_overflow;
   logic        r_underflow;

   logic        w_full;
   logic        w_empty;
   logic        w_rd_ok;
   logic        w_wr_ok;
   logic        w_mem_we;
   logic        w_mem_re;
   logic [AW:0] w_count_next;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);

   // A write at full is allowed only when a read frees the slot on the same edge.
   assign w_rd_ok = i_re & ~w_empty;
   assign w_wr_ok = i_we & (~w_full | w_rd_ok);

   always_comb begin
      w_count_next = r_count;
      if (w_wr_ok && !w_rd_ok)      w_count_next = r_count + 1'b1;
      else if (!w_wr_ok && w_rd_ok) w_count_next = r_count - 1'b1;
   end

   assign w_mem_we = w_wr_ok & ~i_flush & ~i_rst;
   assign w_mem_re = w_rd_ok & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count      <= w_count_next;
         r_dout_valid <= w_rd_ok;
         r_overflow   <= r_overflow  | (i_we & ~w_wr_ok);
         r_underflow  <= r_underflow | (i_re & ~w_rd_ok);
      end
   end

   fifo_mem_sdp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_mem_we),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (i_din),
      .i_re    (w_mem_re),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (o_dout)
   );

   assign o_dout_valid   = r_dout_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= C_AF);
   assign o_almost_empty = (r_count <= C_AE);
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed + randomized bench for sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic             clk = 1'b0;
   logic             rst, flush, we, re;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_valid, full, empty, almost_full, almost_empty;
   logic [4:0]       count;
   logic             overflow, underflow;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] q[$];
   logic [7:0] m_dout = 8'h00;
   logic       m_dv   = 1'b0;
   logic       m_ovf  = 1'b0;
   logic       m_unf  = 1'b0;

   sync_fifo_flags #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_din          (din),
      .i_we           (we),
      .i_re           (re),
      .o_dout         (dout),
      .o_dout_valid   (dout_valid),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_count        (count),
      .o_overflow     (overflow),
      .o_underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
      chk({tag, ".dvalid"}, 32'(dout_valid), 32'(m_dv));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
   endtask

   // One clock: drive on the falling edge, advance the model, check just after the rising edge.
   task automatic step(input string tag, input logic s_we, input logic s_re,
                       input logic [7:0] s_din, input logic s_flush, input logic s_rst);
      logic rd, wr;
      @(negedge clk);
      we = s_we; re = s_re; din = s_din; flush = s_flush; rst = s_rst;
      if (s_rst) begin
         q.delete(); m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (s_flush) begin
         q.delete(); m_dv = 1'b0;
      end else begin
         rd = s_re && (q.size() > 0);
         wr = s_we && ((q.size() < DEPTH) || rd);
         if (rd) m_dout = q.pop_front();
         if (wr) q.push_back(s_din);
         m_dv  = rd;
         m_ovf = m_ovf | (s_we & ~wr);
         m_unf = m_unf | (s_re & ~rd);
      end
      @(posedge clk);
      #1;
      check_all(tag);
      $display("step %-8s we=%0b re=%0b din=%02h fl=%0b rst=%0b -> cnt=%0d dout=%02h dv=%0b ovf=%0b unf=%0b",
               tag, s_we, s_re, s_din, s_flush, s_rst, count, dout, dout_valid, overflow, underflow);
   endtask

   initial begin
      logic [7:0] nxt;
      logic       w, r;
      rst = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; din = '0;

      // Reset, then idle
      step("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_empty", 32'(empty), 32'd1);

      // Fill to full, then overflow write
      for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      chk("full_after16", 32'(full), 32'd1);
      step("ovfwr", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         step("drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         chk("drain_order", 32'(dout), 32'(i));
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Simultaneous read+write at full
      for (int i = 1; i <= 16; i++) step("refill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      step("rwfull", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      chk("rwfull_dout", 32'(dout), 32'h01);
      chk("rwfull_cnt", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("last_is_55", 32'(dout), 32'h55);

      // Simultaneous read+write at empty: no fall-through
      step("rwempty", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("rwempty_cnt", 32'(count), 32'd1);
      chk("rwempty_dv", 32'(dout_valid), 32'd0);
      step("rd77", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("rd77_dout", 32'(dout), 32'h77);

      // Wrap with occupancy bounded to 0..5, no errors expected after fresh reset
      step("reset2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      nxt = 8'h00;
      for (int i = 0; i < 40; i++) begin
         w = (q.size() < 5) && (($urandom_range(0, 2) != 0) || q.size() == 0);
         r = (q.size() > 0) && (($urandom_range(0, 2) != 0) || q.size() == 5);
         step("wrap", w, r, nxt, 1'b0, 1'b0);
         if (w) nxt = nxt + 8'h01;
      end
      chk("wrap_noovf", 32'(overflow), 32'd0);
      chk("wrap_nounf", 32'(underflow), 32'd0);

      // Flush keeps the sticky error bits
      while (q.size() > 0) step("empty", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step("underrd", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step("load9", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
      step("flush", 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
      chk("flush_cnt", 32'(count), 32'd0);
      chk("flush_unf", 32'(underflow), 32'd1);

      // Reset in the middle of a read/write burst
      for (int i = 0; i < 4; i++) step("burst", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      step("rstmid", 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("rstmid_dout", 32'(dout), 32'h00);
      chk("rstmid_unf", 32'(underflow), 32'd0);

      // Randomized mix including occasional flush and reset
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom), 1'($urandom), 8'($urandom),
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
